int32_to_float754: RTL and testbench

Iterative integer-to-IEEE-754 single-precision converter sitting directly upstream of `booth_algorithm_divider`. It turns raw 32-bit sensor/accumulator integers into the fp32 operands the divider consumes on `divident`/`divisor`. It normalises by shifting one bit per cycle, then rounds to nearest, ties to even. Its start/busy/valid handshake matches the divider so the two chain without glue.

---
 rtl/float754_pkg.sv | 25 ++
 rtl/rne_round23.sv | 28 ++
 rtl/int32_to_float754.sv | 133 +++++++++++++
 tb/tb_int32_to_float754.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/float754_pkg.sv
// Shared fp32 definitions for the integer converter and the divider datapath.
package float754_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int INT_W     = 32;

  // Biased exponent of a magnitude whose leading one sits at bit INT_W-1
  // with no normalising shifts applied. Each shift subtracts one from it.
  localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + INT_W - 1);

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2
  } conv_state_e;

endpackage

// File: rtl/rne_round23.sv
// Round-to-nearest, ties-to-even on a 23-bit fraction with guard and sticky.
// A fraction carry-out renormalises by bumping the exponent.
module rne_round23
  import float754_pkg::*;
(
  input  logic [FP_FRAC_W-1:0] frac_i,
  input  logic                 guard_i,
  input  logic                 sticky_i,
  input  logic [FP_EXP_W-1:0]  exp_i,
  output logic [FP_FRAC_W-1:0] frac_o,
  output logic [FP_EXP_W-1:0]  exp_o,
  output logic                 inexact_o
);

  logic                 round_up;
  logic [FP_FRAC_W:0]   frac_sum;

  // Increment on guard when past the halfway point or when the tie breaks to even.
  always_comb begin
    round_up  = guard_i & (sticky_i | frac_i[0]);
    frac_sum  = {1'b0, frac_i} + {{FP_FRAC_W{1'b0}}, round_up};
    // On carry-out the low bits are already all zero, i.e. the fraction wraps to 0.
    frac_o    = frac_sum[FP_FRAC_W-1:0];
    exp_o     = exp_i + {{(FP_EXP_W-1){1'b0}}, frac_sum[FP_FRAC_W]};
    inexact_o = guard_i | sticky_i;
  end

endmodule

// File: rtl/int32_to_float754.sv
// Iterative int32/uint32 to fp32 converter: one normalising shift per cycle,
// then a single round-to-nearest-even step. Handshake matches the divider.
module int32_to_float754
  import float754_pkg::*;
#(
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_flag,
  input  logic [INT_W-1:0]  data_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic              error_o,
  output logic              inexact_o,
  output logic [INT_W-1:0]  result_o
);

  conv_state_e         state_q, state_d;
  logic                sign_q, sign_d;
  logic [INT_W-1:0]    mag_q, mag_d;
  logic [4:0]          lz_q, lz_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic                inexact_q, inexact_d;
  fp32_t               result_q, result_d;

  logic                in_neg;
  logic [INT_W-1:0]    in_mag;
  logic [FP_FRAC_W-1:0] rnd_frac;
  logic [FP_EXP_W-1:0]  rnd_exp;
  logic                 rnd_inexact;

  // Sign and magnitude of the incoming operand; -2^31 maps to 0x80000000.
  always_comb begin
    in_neg = SIGNED_MODE && data_i[INT_W-1];
    in_mag = in_neg ? (~data_i + 32'd1) : data_i;
  end

  rne_round23 u_round (
    .frac_i    (mag_q[30:8]),
    .guard_i   (mag_q[7]),
    .sticky_i  (|mag_q[6:0]),
    .exp_i     (EXP_TOP - {3'b000, lz_q}),
    .frac_o    (rnd_frac),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inexact)
  );

  // Next-state and datapath updates for IDLE -> NORM -> ROUND.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    lz_d      = lz_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    inexact_d = inexact_q;
    result_d  = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_flag) begin
          sign_d = in_neg;
          mag_d  = in_mag;
          lz_d   = 5'd0;
          if (in_mag == '0) begin
            result_d  = '0;
            inexact_d = 1'b0;
            valid_d   = 1'b1;
          end else begin
            state_d = ST_NORM;
            busy_d  = 1'b1;
          end
        end
      end
      ST_NORM: begin
        error_d = start_flag;
        if (!mag_q[INT_W-1]) begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + 5'd1;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        error_d   = start_flag;
        result_d  = '{sign: sign_q, exp: rnd_exp, frac: rnd_frac};
        inexact_d = rnd_inexact;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      lz_q      <= 5'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      inexact_q <= 1'b0;
      result_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      lz_q      <= lz_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      inexact_q <= inexact_d;
      result_q  <= result_d;
    end
  end

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign error_o   = error_q;
  assign inexact_o = inexact_q;
  assign result_o  = result_q;

endmodule

// File: tb/tb_int32_to_float754.sv
// Self-checking bench for int32_to_float754: directed table, corner
// sequences and random operands against an arithmetic reference model.
module tb_int32_to_float754;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_s = 1'b0, start_u = 1'b0;
  logic [31:0] data_s = '0, data_u = '0;
  logic        busy_s, valid_s, error_s, inexact_s;
  logic        busy_u, valid_u, error_u, inexact_u;
  logic [31:0] result_s, result_u;

  logic        sel_u = 1'b0;
  logic        cur_busy, cur_valid, cur_error, cur_inexact;
  logic [31:0] cur_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int32_to_float754 #(.SIGNED_MODE(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_flag(start_s), .data_i(data_s),
    .busy_o(busy_s), .valid_o(valid_s), .error_o(error_s),
    .inexact_o(inexact_s), .result_o(result_s)
  );

  int32_to_float754 #(.SIGNED_MODE(1'b0)) dut_u (
    .clk_i(clk), .rst_i(rst), .start_flag(start_u), .data_i(data_u),
    .busy_o(busy_u), .valid_o(valid_u), .error_o(error_u),
    .inexact_o(inexact_u), .result_o(result_u)
  );

  assign cur_busy    = sel_u ? busy_u    : busy_s;
  assign cur_valid   = sel_u ? valid_u   : valid_s;
  assign cur_error   = sel_u ? error_u   : error_s;
  assign cur_inexact = sel_u ? inexact_u : inexact_s;
  assign cur_result  = sel_u ? result_u  : result_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: value-level conversion with exact integer arithmetic.
  // off = number of clock edges after the accepting edge until valid is seen.
  function automatic void ref_model(input bit u, input logic [31:0] d,
                                    output logic [31:0] res, output logic inx,
                                    output int off);
    longint mag, sig, rem, half;
    int p, e, sh;
    bit s;
    s   = !u && d[31];
    mag = longint'({32'd0, d});
    if (s) mag = 64'd4294967296 - mag;
    if (mag == 0) begin
      res = 32'h0; inx = 1'b0; off = 0;
      return;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = 127 + p;
    if (p <= 23) begin
      sig = mag << (23 - p);
      inx = 1'b0;
    end else begin
      sh   = p - 23;
      sig  = mag >> sh;
      rem  = mag - (sig << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && sig[0])) sig++;
      inx = (rem != 0);
      if (sig == (longint'(1) << 24)) begin
        sig = sig >> 1;
        e++;
      end
    end
    res = {s, e[7:0], sig[22:0]};
    off = (31 - p) + 2;
  endfunction

  // Start a conversion at the next edge and check result, flags and latency.
  task automatic convert(input string tag, input bit u, input logic [31:0] d,
                         input logic [31:0] exp_res, input logic exp_inx, input int exp_off);
    int off;
    bit seen;
    @(negedge clk);
    sel_u = u;
    if (u) begin start_u = 1'b1; data_u = d; end
    else   begin start_s = 1'b1; data_s = d; end
    @(posedge clk);
    #1;
    start_s = 1'b0;
    start_u = 1'b0;
    off  = 0;
    seen = cur_valid;
    if (!seen && exp_off == 0) check({tag, "_busy_zero"}, {31'd0, cur_busy}, 32'd0);
    if (!seen && exp_off > 0)  check({tag, "_busy_start"}, {31'd0, cur_busy}, 32'd1);
    while (!seen && off < 40) begin
      @(posedge clk);
      #1;
      off++;
      seen = cur_valid;
    end
    check({tag, "_valid_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, off, exp_off);
    check({tag, "_result"}, cur_result, exp_res);
    check({tag, "_inexact"}, {31'd0, cur_inexact}, {31'd0, exp_inx});
    check({tag, "_busy_at_valid"}, {31'd0, cur_busy}, 32'd0);
  endtask

  typedef struct {
    string       name;
    bit          u;
    logic [31:0] data;
    logic [31:0] res;
    logic        inx;
    int          off;
  } vec_t;

  initial begin
    vec_t vecs[11];
    logic [31:0] r_res, d;
    logic        r_inx;
    int          r_off, errs, valids;
    bit          u;

    vecs[0]  = '{"int75",     1'b0, 32'd75,        32'h42960000, 1'b0, 27};
    vecs[1]  = '{"int5",      1'b0, 32'd5,         32'h40A00000, 1'b0, 31};
    vecs[2]  = '{"neg1",      1'b0, 32'hFFFFFFFF,  32'hBF800000, 1'b0, 33};
    vecs[3]  = '{"minint",    1'b0, 32'h80000000,  32'hCF000000, 1'b0, 2};
    vecs[4]  = '{"zero",      1'b0, 32'd0,         32'h00000000, 1'b0, 0};
    vecs[5]  = '{"tie_even",  1'b0, 32'd16777217,  32'h4B800000, 1'b1, 9};
    vecs[6]  = '{"tie_odd",   1'b0, 32'd16777219,  32'h4B800002, 1'b1, 9};
    vecs[7]  = '{"carry",     1'b0, 32'h7FFFFFFF,  32'h4F000000, 1'b1, 3};
    vecs[8]  = '{"u_max",     1'b1, 32'hFFFFFFFF,  32'h4F800000, 1'b1, 2};
    vecs[9]  = '{"u_msb",     1'b1, 32'h80000000,  32'h4F000000, 1'b0, 2};
    vecs[10] = '{"one",       1'b0, 32'd1,         32'h3F800000, 1'b0, 33};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    {30'd0, busy_s, busy_u},       32'd0);
    check("rst_valid",   {30'd0, valid_s, valid_u},     32'd0);
    check("rst_error",   {30'd0, error_s, error_u},     32'd0);
    check("rst_inexact", {30'd0, inexact_s, inexact_u}, 32'd0);
    check("rst_result_s", result_s, 32'h0);
    check("rst_result_u", result_u, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; each start lands in the previous valid cycle.
    foreach (vecs[i])
      convert(vecs[i].name, vecs[i].u, vecs[i].data, vecs[i].res, vecs[i].inx, vecs[i].off);

    // Start issued while valid is high must be accepted.
    convert("b2b_75", 1'b0, 32'd75, 32'h42960000, 1'b0, 27);
    check("b2b_valid_high", {31'd0, valid_s}, 32'd1);
    convert("b2b_5", 1'b0, 32'd5, 32'h40A00000, 1'b0, 31);

    // start_flag held for three cycles during a conversion of 1.
    @(negedge clk);
    sel_u = 1'b0;
    start_s = 1'b1;
    data_s  = 32'd1;
    @(posedge clk);
    #1;
    data_s = 32'h00001234;
    check("hold_no_err_on_accept", {31'd0, error_s}, 32'd0);
    errs = 0;
    r_off = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      r_off++;
      if (error_s) errs++;
    end
    start_s = 1'b0;
    while (!valid_s && r_off < 40) begin
      @(posedge clk);
      #1;
      r_off++;
      if (error_s) errs++;
    end
    check("hold_err_count", errs, 3);
    check("hold_latency", r_off, 33);
    check("hold_result", result_s, 32'h3F800000);

    // Reset at cycle 10 of a conversion of 1 aborts it.
    @(negedge clk);
    start_s = 1'b1;
    data_s  = 32'd1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy",    {31'd0, busy_s},    32'd0);
    check("abort_valid",   {31'd0, valid_s},   32'd0);
    check("abort_error",   {31'd0, error_s},   32'd0);
    check("abort_inexact", {31'd0, inexact_s}, 32'd0);
    check("abort_result",  result_s,           32'h0);
    @(negedge clk);
    rst = 1'b0;
    valids = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid_s) valids++;
    end
    check("abort_no_valid", valids, 0);

    // Random operands, spread over all leading-zero counts.
    for (int i = 0; i < 150; i++) begin
      u = 1'($urandom_range(0, 1));
      d = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) d = -d;
      ref_model(u, d, r_res, r_inx, r_off);
      convert($sformatf("rnd%0d", i), u, d, r_res, r_inx, r_off);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
